// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared helpers for the neural-network layer flow controllers.
// Holds counter-width helpers and a parameter sanity check used at elaboration.
`ifndef NN_CTRL_PKG_SV
`define NN_CTRL_PKG_SV

// Elaboration-time guard: instantiate inside a module body after parameters.
`define NN_CTRL_CHECK_PARAMS(delay_p, depth_p) \
   if (!nn_ctrl_pkg::params_ok((delay_p), (depth_p))) begin : g_param_error \
      $error("nn_ctrl: DELAY and FIFO_DEPTH must both be >= 1"); \
   end

package nn_ctrl_pkg;

   // Bits needed to hold any value in 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Bits needed to address depth entries; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // True when the controller parameters describe a buildable design.
   function automatic bit params_ok(input int delay, input int depth);
      return (delay >= 1) && (depth >= 1);
   endfunction

endpackage

`endif

// File: rtl/delay_v_sched_if.sv
// delay_v_sched_if: upstream stream, datapath launch/return and downstream
// stream of the delay_v scheduler grouped into one bundle.
interface delay_v_sched_if #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic [LENGTH-1:0][WIDTH-1:0] in_data;
   logic [LENGTH-1:0][WIDTH-1:0] pipe_a;
   logic [LENGTH-1:0][WIDTH-1:0] pipe_c;
   logic                         out_valid;
   logic                         out_ready;
   logic [LENGTH-1:0][WIDTH-1:0] out_data;

   // Environment side: produces input vectors, hosts the datapath, consumes output.
   modport master (
      output in_valid, in_data, pipe_c, out_ready,
      input  in_ready, pipe_a, out_valid, out_data
   );

   // Scheduler side.
   modport slave (
      input  in_valid, in_data, pipe_c, out_ready,
      output in_ready, pipe_a, out_valid, out_data
   );
endinterface

// File: rtl/sync_fifo_v.sv
// sync_fifo_v: first-word-fall-through FIFO of LENGTH x WIDTH vectors.
// Head entry is visible combinationally from the storage array; a write into
// an empty FIFO shows up on head_data the cycle after the write edge.
module sync_fifo_v
   import nn_ctrl_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 4,
   parameter int DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           push,
   input  logic [LENGTH-1:0][WIDTH-1:0]   push_data,
   input  logic                           pop,
   output logic [LENGTH-1:0][WIDTH-1:0]   head_data,
   output logic                           full,
   output logic                           empty,
   output logic [cnt_width(DEPTH)-1:0]    count
);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [LENGTH-1:0][WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // A pop of an empty FIFO is ignored; the caller is trusted not to overfill.
   assign do_pop  = pop & (count_reg != '0);
   assign do_push = push;

   assign full      = (count_reg == FULL_CNT);
   assign empty     = (count_reg == '0);
   assign count     = count_reg;
   assign head_data = mem[rd_ptr_reg];

   // Next pointers and occupancy from this cycle's push/pop.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (do_push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage array: write-only port, contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

endmodule

// File: rtl/delay_v_sched.sv
// delay_v_sched: launches vectors into a fixed-latency, non-stallable vector
// datapath, tracks which pipeline slots hold live data and collects the
// results in an output FIFO. Admission is credit based: a credit is taken on
// admit and only returned when the vector leaves the FIFO, so the FIFO can
// never overflow no matter how long downstream stalls. Because a credit is
// held from the admit edge until the pop edge, sustained one-vector-per-clock
// flow needs FIFO_DEPTH >= DELAY+2.
module delay_v_sched
   import nn_ctrl_pkg::*;
#(
   parameter int DELAY      = 3,
   parameter int WIDTH      = 8,
   parameter int LENGTH     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   delay_v_sched_if.slave                bus,
   output logic [cnt_width(DELAY)-1:0]   inflight,
   output logic                          busy
);
   localparam int CRED_W = cnt_width(FIFO_DEPTH);
   localparam int INF_W  = cnt_width(DELAY);
   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);

   `NN_CTRL_CHECK_PARAMS(DELAY, FIFO_DEPTH)

   logic                         admit;
   logic                         pop;
   logic                         cap;
   logic                         fifo_push;
   logic [CRED_W-1:0]            credits_reg, credits_next;
   logic [INF_W-1:0]             inflight_reg, inflight_next;
   logic [DELAY-1:0]             vld_sr_reg, vld_sr_next;
   logic [LENGTH-1:0][WIDTH-1:0] fifo_head;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [CRED_W-1:0]            fifo_count;

   // Handshakes. in_ready depends only on the credit register, which keeps
   // out_ready from ever reaching in_ready combinationally.
   assign bus.in_ready  = (credits_reg != '0);
   assign admit         = bus.in_valid & bus.in_ready;
   assign bus.out_valid = ~fifo_empty;
   assign bus.out_data  = fifo_head;
   assign pop           = bus.out_valid & bus.out_ready;

   // The datapath is launched straight from the upstream bus.
   assign bus.pipe_a = bus.in_data;

   // Top of the valid shift register lines up with a live beat on pipe_c.
   assign cap = vld_sr_reg[DELAY-1];

   // Credits make a full FIFO impossible here; the full term only protects
   // the storage if that invariant were ever broken.
   assign fifo_push = cap & (~fifo_full | pop);

   assign inflight = inflight_reg;
   assign busy     = (inflight_reg != '0) | (fifo_count != '0);

   // Valid shift register input: new launch enters at bit 0, rest shifts up.
   generate
      if (DELAY == 1) begin : g_sr_one
         assign vld_sr_next = admit;
      end else begin : g_sr_many
         assign vld_sr_next = {vld_sr_reg[DELAY-2:0], admit};
      end
   endgenerate

   // Credit and in-flight counter updates.
   always_comb begin
      credits_next  = credits_reg;
      inflight_next = inflight_reg;
      case ({admit, pop})
         2'b10:   credits_next = credits_reg - CRED_W'(1);
         2'b01:   credits_next = credits_reg + CRED_W'(1);
         default: credits_next = credits_reg;
      endcase
      case ({admit, cap})
         2'b10:   inflight_next = inflight_reg + INF_W'(1);
         2'b01:   inflight_next = inflight_reg - INF_W'(1);
         default: inflight_next = inflight_reg;
      endcase
   end

   // Scheduler state registers; the shift register advances every clock.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         credits_reg  <= CRED_FULL;
         inflight_reg <= '0;
         vld_sr_reg   <= '0;
      end else begin
         credits_reg  <= credits_next;
         inflight_reg <= inflight_next;
         vld_sr_reg   <= vld_sr_next;
      end
   end

   sync_fifo_v #(
      .WIDTH  (WIDTH),
      .LENGTH (LENGTH),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (bus.pipe_c),
      .pop       (pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_delay_v_sched.sv
// tb_delay_v_sched: two scheduler instances (DELAY=3/FIFO_DEPTH=4 and
// DELAY=1/FIFO_DEPTH=2), each fed by a delay_v datapath and checked every
// cycle against a queue-level model, plus directed literal checks.
module tb_delay_v_sched;

   typedef logic [3:0][7:0] vec_t;
   typedef struct {
      vec_t d;
      int   t;
   } item_t;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   logic in_valid_s  [2];
   vec_t in_data_s   [2];
   logic out_ready_s [2];
   logic rstn_s      [2];
   logic in_ready_s  [2];
   logic out_valid_s [2];
   vec_t out_data_s  [2];
   vec_t pipe_c_s    [2];
   int   inflight_s  [2];
   logic busy_s      [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input int k);
      vec_t v;
      for (int i = 0; i < 4; i++) v[i] = 8'(4 * k + i + 1);
      return v;
   endfunction

   task automatic chk(input string name, input int cfg, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, name, got, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int D  = (gi == 0) ? 3 : 1;
      localparam int FD = (gi == 0) ? 4 : 2;

      delay_v_sched_if #(.WIDTH(8), .LENGTH(4)) bus ();
      logic [$clog2(D+1)-1:0] inflight;
      logic                   busy;

      delay_v_sched #(
         .DELAY(D), .WIDTH(8), .LENGTH(4), .FIFO_DEPTH(FD)
      ) dut (
         .clk      (clk),
         .rstn     (rstn_s[gi]),
         .bus      (bus),
         .inflight (inflight),
         .busy     (busy)
      );

      assign bus.in_valid   = in_valid_s[gi];
      assign bus.in_data    = in_data_s[gi];
      assign bus.out_ready  = out_ready_s[gi];
      assign in_ready_s[gi] = bus.in_ready;
      assign out_valid_s[gi] = bus.out_valid;
      assign out_data_s[gi] = bus.out_data;
      assign pipe_c_s[gi]   = bus.pipe_c;
      assign inflight_s[gi] = int'(inflight);
      assign busy_s[gi]     = busy;

      // delay_v datapath: D register stages, never stalls, never reset.
      vec_t dp [D];
      always @(posedge clk) begin
         dp[0] <= bus.pipe_a;
         for (int i = 1; i < D; i++) dp[i] <= dp[i-1];
      end
      assign bus.pipe_c = dp[D-1];

      // Model: a vector admitted at edge n reaches the FIFO at edge n+D;
      // it holds a credit from admission until it is popped.
      vec_t  fifo_q [$];
      item_t inf_q  [$];
      int    edge_n  = 0;
      bit    started = 0;

      always @(posedge clk) begin
         bit    rdy, adm, pp;
         item_t it;
         edge_n++;
         if (!rstn_s[gi]) begin
            fifo_q.delete();
            inf_q.delete();
            started = 1;
         end else if (started) begin
            rdy = (fifo_q.size() + inf_q.size()) < FD;
            adm = in_valid_s[gi] && rdy;
            pp  = (fifo_q.size() != 0) && out_ready_s[gi];
            if (pp) void'(fifo_q.pop_front());
            while (inf_q.size() != 0 && inf_q[0].t == edge_n) begin
               it = inf_q.pop_front();
               fifo_q.push_back(it.d);
            end
            if (adm) begin
               it.d = in_data_s[gi];
               it.t = edge_n + D;
               inf_q.push_back(it);
            end
            chk("fifo_overflow", gi, 64'(fifo_q.size() <= FD), 64'd1);
         end
      end

      // Compare DUT outputs with the model mid-cycle.
      always @(negedge clk) begin
         int nf, ninf;
         if (started) begin
            nf   = fifo_q.size();
            ninf = inf_q.size();
            chk("in_ready", gi, 64'(in_ready_s[gi]), 64'((nf + ninf) < FD));
            chk("out_valid", gi, 64'(out_valid_s[gi]), 64'(nf != 0));
            if (nf != 0) chk("out_data", gi, 64'(out_data_s[gi]), 64'(fifo_q[0]));
            chk("inflight", gi, 64'(inflight_s[gi]), 64'(ninf));
            chk("busy", gi, 64'(busy_s[gi]), 64'((nf + ninf) != 0));
            if (out_valid_s[gi] && out_ready_s[gi])
               $display("cfg%0d pop  %h at %0t", gi, out_data_s[gi], $time);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer vectors base..base+n-1 for at most ncyc cycles; acc = number taken.
   task automatic stream(input int cfg, input int n, input int base, input int ncyc, output int acc);
      bit rdy;
      acc = 0;
      for (int c = 0; c < ncyc && acc < n; c++) begin
         in_valid_s[cfg] = 1'b1;
         in_data_s[cfg]  = mk(base + acc);
         @(negedge clk);
         rdy = in_ready_s[cfg];
         @(posedge clk);
         #1;
         if (rdy) begin
            $display("cfg%0d push %h at %0t", cfg, in_data_s[cfg], $time);
            acc++;
         end
      end
      in_valid_s[cfg] = 1'b0;
   endtask

   initial begin
      int acc, seen;
      for (int i = 0; i < 2; i++) begin
         in_valid_s[i]  = 1'b0;
         in_data_s[i]   = '0;
         out_ready_s[i] = 1'b0;
         rstn_s[i]      = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rstn_s[0] = 1'b1;
      rstn_s[1] = 1'b1;

      // Reset state
      chk("rst_in_ready", 0, 64'(in_ready_s[0]), 64'd1);
      chk("rst_out_valid", 0, 64'(out_valid_s[0]), 64'd0);
      chk("rst_inflight", 0, 64'(inflight_s[0]), 64'd0);
      chk("rst_busy", 0, 64'(busy_s[0]), 64'd0);
      chk("rst_credits", 0, 64'(g_cfg[0].dut.credits_reg), 64'd4);
      chk("rst_credits", 1, 64'(g_cfg[1].dut.credits_reg), 64'd2);

      // Single vector {1,2,3,4}
      out_ready_s[0] = 1'b1;
      idle(2);
      stream(0, 1, 0, 20, acc);
      chk("single_acc", 0, 64'(acc), 64'd1);
      chk("single_inflight1", 0, 64'(inflight_s[0]), 64'd1);
      idle(2);
      chk("single_pipe_c", 0, 64'(pipe_c_s[0]), 64'h04030201);
      idle(1);
      chk("single_out_valid", 0, 64'(out_valid_s[0]), 64'd1);
      chk("single_out_data", 0, 64'(out_data_s[0]), 64'h04030201);
      chk("single_inflight0", 0, 64'(inflight_s[0]), 64'd0);
      idle(1);
      chk("single_busy_after_pop", 0, 64'(busy_s[0]), 64'd0);

      // Streaming 8 vectors with downstream always ready
      stream(0, 8, 10, 24, acc);
      chk("stream_acc", 0, 64'(acc), 64'd8);
      idle(8);
      chk("stream_drained", 0, 64'(busy_s[0]), 64'd0);

      // Backpressure: 6 offered, 4 accepted
      out_ready_s[0] = 1'b0;
      stream(0, 6, 20, 6, acc);
      chk("bp_acc", 0, 64'(acc), 64'd4);
      chk("bp_in_ready_low", 0, 64'(in_ready_s[0]), 64'd0);
      idle(4);
      chk("bp_in_ready_still_low", 0, 64'(in_ready_s[0]), 64'd0);
      out_ready_s[0] = 1'b1;
      idle(1);
      chk("bp_in_ready_after_pop", 0, 64'(in_ready_s[0]), 64'd1);
      idle(6);

      // credits=1 with admit, pop and an arrival on the same edge
      out_ready_s[0] = 1'b0;
      stream(0, 3, 30, 3, acc);
      chk("c1_setup_acc", 0, 64'(acc), 64'd3);
      idle(2);
      chk("c1_credits_before", 0, 64'(g_cfg[0].dut.credits_reg), 64'd1);
      out_ready_s[0] = 1'b1;
      stream(0, 1, 33, 1, acc);
      out_ready_s[0] = 1'b0;
      chk("c1_acc", 0, 64'(acc), 64'd1);
      chk("c1_credits", 0, 64'(g_cfg[0].dut.credits_reg), 64'd1);
      chk("c1_in_ready", 0, 64'(in_ready_s[0]), 64'd1);
      chk("c1_fifo_count", 0, 64'(g_cfg[0].dut.u_fifo.count_reg), 64'd2);
      out_ready_s[0] = 1'b1;
      idle(8);

      // Reset with 2 vectors in flight and 2 in the FIFO
      out_ready_s[0] = 1'b0;
      stream(0, 2, 40, 2, acc);
      idle(4);
      stream(0, 2, 42, 2, acc);
      chk("rm_acc", 0, 64'(acc), 64'd2);
      rstn_s[0] = 1'b0;
      idle(1);
      chk("rm_out_valid", 0, 64'(out_valid_s[0]), 64'd0);
      chk("rm_inflight", 0, 64'(inflight_s[0]), 64'd0);
      chk("rm_credits", 0, 64'(g_cfg[0].dut.credits_reg), 64'd4);
      rstn_s[0] = 1'b1;
      out_ready_s[0] = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid_s[0]) seen++;
      end
      @(posedge clk);
      #1;
      chk("rm_no_stale_output", 0, 64'(seen), 64'd0);

      // DELAY=1, FIFO_DEPTH=2: one-clock latency, 5 vectors in order
      out_ready_s[1] = 1'b1;
      stream(1, 1, 60, 1, acc);
      chk("d1_acc0", 1, 64'(acc), 64'd1);
      chk("d1_no_bypass", 1, 64'(out_valid_s[1]), 64'd0);
      stream(1, 1, 61, 1, acc);
      chk("d1_acc1", 1, 64'(acc), 64'd1);
      chk("d1_latency_valid", 1, 64'(out_valid_s[1]), 64'd1);
      chk("d1_latency_data", 1, 64'(out_data_s[1]), 64'hF4F3F2F1);
      stream(1, 3, 62, 12, acc);
      chk("d1_acc_rest", 1, 64'(acc), 64'd3);
      idle(6);
      chk("d1_drained", 1, 64'(busy_s[1]), 64'd0);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
